multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/imm_gen.sv | 17 +
 rtl/multicycle_control_unit.sv | 109 ++++++++++
 tb/tb_multicycle_control_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, funct fields, ALU codes and FSM state encoding
package riscv_pkg;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_TRAP      = 3'd5
    } state_t;
    // R-type and I-type share the same funct3 meaning for add/and/or
    function automatic logic [2:0] alu_of(input logic [2:0] f3);
        return f3 == F3_AND ? ALU_AND : f3 == F3_OR ? ALU_OR : ALU_ADD;
    endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate extraction for I, S and B formats
module imm_gen import riscv_pkg::*; #(
    parameter int WORDSIZE = 64
) (
    input  logic [31:0]         ir,
    output logic [WORDSIZE-1:0] imm
);
    logic [6:0] op;
    logic [WORDSIZE-1:0] i_imm, s_imm, b_imm;
    assign op    = ir[6:0];
    assign i_imm = {{(WORDSIZE-12){ir[31]}}, ir[31:20]};
    assign s_imm = {{(WORDSIZE-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign b_imm = {{(WORDSIZE-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm   = (op == OP_I || op == OP_LW) ? i_imm :
                   op == OP_SW  ? s_imm :
                   op == OP_BEQ ? b_imm : '0;
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for a small RV subset
module multicycle_control_unit import riscv_pkg::*; #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [INSTRUCTION_SIZE-1:0] instruction,
    input  logic                        instr_valid,
    input  logic                        alu_zero,
    input  logic                        dm_ready,
    output logic [4:0]                  cu_rf_addr_a,
    output logic [4:0]                  cu_rf_addr_b,
    output logic [4:0]                  cu_rf_write_addr,
    output logic                        cu_rf_write_en,
    output logic [WORDSIZE-1:0]         cu_immediate,
    output logic                        cu_mux_1_sel,
    output logic                        cu_mux_2_sel,
    output logic [2:0]                  cu_alu_operation,
    output logic                        cu_dm_read_en,
    output logic                        cu_dm_write_en,
    output logic                        cu_pc_write_en,
    output logic                        cu_pc_src,
    output logic                        cu_illegal,
    output logic [2:0]                  cu_state
);
    state_t state, state_nxt;
    logic [INSTRUCTION_SIZE-1:0] ir;
    logic illegal;
    logic [6:0] opcode, f7;
    logic [2:0] f3, alu_sel;
    logic is_r, is_i, is_lw, is_sw, is_beq, legal;

    assign opcode = ir[6:0];
    assign f3     = ir[14:12];
    assign f7     = ir[31:25];
    assign is_r   = opcode == OP_R && ((f7 == F7_BASE && (f3 == F3_ADD || f3 == F3_AND || f3 == F3_OR)) ||
                                       (f7 == F7_SUB && f3 == F3_ADD));
    assign is_i   = opcode == OP_I && (f3 == F3_ADD || f3 == F3_AND || f3 == F3_OR);
    assign is_lw  = opcode == OP_LW && f3 == F3_W;
    assign is_sw  = opcode == OP_SW && f3 == F3_W;
    assign is_beq = opcode == OP_BEQ && f3 == F3_BEQ;
    assign legal  = is_r || is_i || is_lw || is_sw || is_beq;
    assign alu_sel = (is_r && f7 == F7_SUB) ? ALU_SUB : (is_r || is_i) ? alu_of(f3) : ALU_ADD;

    assign cu_rf_addr_a     = ir[19:15];
    assign cu_rf_addr_b     = ir[24:20];
    assign cu_rf_write_addr = ir[11:7];
    assign cu_illegal       = illegal;
    assign cu_state         = state;

    imm_gen #(.WORDSIZE(WORDSIZE)) u_imm_gen (
        .ir  (ir[31:0]),
        .imm (cu_immediate)
    );

    // State, instruction register and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            ir      <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && instr_valid) ir <= instruction;
            if (state == S_DECODE && !legal) illegal <= 1'b1;
        end
    end

    // Next-state and per-state control strobes; everything idles unless a state claims it
    always_comb begin
        state_nxt        = state;
        cu_rf_write_en   = 1'b0;
        cu_mux_1_sel     = 1'b0;
        cu_mux_2_sel     = 1'b0;
        cu_alu_operation = ALU_ADD;
        cu_dm_read_en    = 1'b0;
        cu_dm_write_en   = 1'b0;
        cu_pc_write_en   = 1'b0;
        cu_pc_src        = 1'b0;
        case (state)
            S_FETCH:  state_nxt = instr_valid ? S_DECODE : S_FETCH;
            S_DECODE: state_nxt = legal ? S_EXECUTE : S_TRAP;
            S_EXECUTE: begin
                cu_alu_operation = is_beq ? ALU_SUB : alu_sel;
                cu_mux_1_sel     = is_r || is_beq;
                cu_pc_write_en   = is_beq;
                cu_pc_src        = is_beq && alu_zero;
                state_nxt        = (is_lw || is_sw) ? S_MEMORY : is_beq ? S_FETCH : S_WRITEBACK;
            end
            S_MEMORY: begin
                cu_dm_read_en  = is_lw;
                cu_dm_write_en = is_sw;
                cu_pc_write_en = is_sw && dm_ready;
                state_nxt      = dm_ready ? (is_lw ? S_WRITEBACK : S_FETCH) : S_MEMORY;
            end
            S_WRITEBACK: begin
                cu_rf_write_en   = ir[11:7] != 5'd0;
                cu_pc_write_en   = 1'b1;
                cu_mux_2_sel     = is_lw;
                cu_alu_operation = alu_sel;
                cu_mux_1_sel     = is_r;
                state_nxt        = S_FETCH;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard-driven directed checks of the control FSM (64- and 32-bit builds)
module tb_multicycle_control_unit;
    import riscv_pkg::*;

    logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, alu_zero = 1'b0, dm_ready = 1'b0;
    logic [31:0] instruction = '0;
    logic [4:0] addr_a, addr_b, waddr, addr_a32, addr_b32, waddr32;
    logic rf_we, m1, m2, dre, dwe, pc_we, pc_src, ill;
    logic rf_we32, m1_32, m2_32, dre32, dwe32, pc_we32, pc_src32, ill32;
    logic [2:0] alu, st, alu32, st32;
    logic [63:0] imm;
    logic [31:0] imm32;
    logic [13:0] obs;
    int checks = 0, errors = 0;

    typedef struct packed {
        logic [31:0] ins;
        logic        iv;
        logic        dr;
        logic        az;
        logic [13:0] e;
    } ent_t;
    ent_t sb[$];
    ent_t en;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .alu_zero(alu_zero), .dm_ready(dm_ready),
        .cu_rf_addr_a(addr_a), .cu_rf_addr_b(addr_b), .cu_rf_write_addr(waddr),
        .cu_rf_write_en(rf_we), .cu_immediate(imm), .cu_mux_1_sel(m1), .cu_mux_2_sel(m2),
        .cu_alu_operation(alu), .cu_dm_read_en(dre), .cu_dm_write_en(dwe),
        .cu_pc_write_en(pc_we), .cu_pc_src(pc_src), .cu_illegal(ill), .cu_state(st)
    );

    multicycle_control_unit #(.WORDSIZE(32)) dut32 (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .alu_zero(alu_zero), .dm_ready(dm_ready),
        .cu_rf_addr_a(addr_a32), .cu_rf_addr_b(addr_b32), .cu_rf_write_addr(waddr32),
        .cu_rf_write_en(rf_we32), .cu_immediate(imm32), .cu_mux_1_sel(m1_32), .cu_mux_2_sel(m2_32),
        .cu_alu_operation(alu32), .cu_dm_read_en(dre32), .cu_dm_write_en(dwe32),
        .cu_pc_write_en(pc_we32), .cu_pc_src(pc_src32), .cu_illegal(ill32), .cu_state(st32)
    );

    assign obs = {st, ill, rf_we, pc_we, pc_src, dre, dwe, m1, m2, alu};

    function automatic logic [13:0] mk(logic [2:0] s, logic il, logic rf, logic pc, logic src,
                                       logic rd, logic wr, logic s1, logic s2, logic [2:0] op);
        return {s, il, rf, pc, src, rd, wr, s1, s2, op};
    endfunction

    function automatic void push(logic [31:0] ins, logic iv, logic dr, logic az, logic [13:0] e);
        sb.push_back('{ins: ins, iv: iv, dr: dr, az: az, e: e});
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000)) begin
            errors++; $display("FAIL reset outputs: got %h expected %h", obs, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        end
        checks++;
        if ({addr_a, addr_b, waddr, imm} !== 79'd0) begin
            errors++; $display("FAIL reset ir: got a=%0d b=%0d w=%0d imm=%h expected zeros", addr_a, addr_b, waddr, imm);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        push(32'h002081B3, 1, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'h002081B3, 0, 0, 0, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'hFFFFFFFF, 0, 0, 0, mk(S_EXECUTE, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000));
        push(32'hFFFFFFFF, 0, 0, 0, mk(S_WRITEBACK, 0, 1, 1, 0, 0, 0, 1, 0, 3'b000));
        push(32'hFFFFFFFF, 0, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        while (sb.size() > 0) begin
            en = sb.pop_front();
            instruction = en.ins; instr_valid = en.iv; dm_ready = en.dr; alu_zero = en.az;
            @(negedge clk);
            checks++;
            if (obs !== en.e) begin errors++; $display("FAIL add cycle: got %h expected %h", obs, en.e); end
            @(posedge clk); #1;
        end
        checks++;
        if ({addr_a, addr_b, waddr} !== {5'd1, 5'd2, 5'd3} || imm !== 64'd0) begin
            errors++; $display("FAIL add fields: got a=%0d b=%0d w=%0d imm=%h expected 1 2 3 0", addr_a, addr_b, waddr, imm);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ins [5] = '{32'h402081B3, 32'h0020F1B3, 32'h0020E1B3, 32'hFFF0F193, 32'hFFF0E193};
        logic [2:0] ops [5] = '{3'b001, 3'b010, 3'b011, 3'b010, 3'b011};
        logic s1 [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++) begin
            push(ins[k], 1, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
            push(ins[k], 0, 0, 0, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
            push(ins[k], 0, 0, 0, mk(S_EXECUTE, 0, 0, 0, 0, 0, 0, s1[k], 0, ops[k]));
            push(ins[k], 0, 0, 0, mk(S_WRITEBACK, 0, 1, 1, 0, 0, 0, s1[k], 0, ops[k]));
        end
        push(32'h0, 0, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        while (sb.size() > 0) begin
            en = sb.pop_front();
            instruction = en.ins; instr_valid = en.iv; dm_ready = en.dr; alu_zero = en.az;
            @(negedge clk);
            checks++;
            if (obs !== en.e) begin errors++; $display("FAIL alu_ops cycle: got %h expected %h", obs, en.e); end
            @(posedge clk); #1;
        end
        checks++;
        if (imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL ori imm: got %h expected all ones", imm); end
    endtask

    task automatic test_lw;
        push(32'hFFC0A283, 1, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'hFFC0A283, 0, 0, 0, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'hFFC0A283, 0, 0, 0, mk(S_EXECUTE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        for (int k = 0; k < 3; k++) push(32'hFFC0A283, 0, 0, 0, mk(S_MEMORY, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000));
        push(32'hFFC0A283, 0, 1, 0, mk(S_MEMORY, 0, 0, 0, 0, 1, 0, 0, 0, 3'b000));
        push(32'hFFC0A283, 0, 0, 0, mk(S_WRITEBACK, 0, 1, 1, 0, 0, 0, 0, 1, 3'b000));
        push(32'hFFC0A283, 0, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        while (sb.size() > 0) begin
            en = sb.pop_front();
            instruction = en.ins; instr_valid = en.iv; dm_ready = en.dr; alu_zero = en.az;
            @(negedge clk);
            checks++;
            if (obs !== en.e) begin errors++; $display("FAIL lw cycle: got %h expected %h", obs, en.e); end
            @(posedge clk); #1;
        end
        checks++;
        if (imm !== 64'hFFFF_FFFF_FFFF_FFFC || imm32 !== 32'hFFFF_FFFC || waddr !== 5'd5 || addr_a !== 5'd1) begin
            errors++; $display("FAIL lw fields: got imm=%h imm32=%h w=%0d a=%0d expected fffffffffffffffc fffffffc 5 1", imm, imm32, waddr, addr_a);
        end
    endtask

    task automatic test_beq;
        for (int z = 1; z >= 0; z--) begin
            push(32'hFE208CE3, 1, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
            push(32'hFE208CE3, 0, 0, 0, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
            push(32'hFE208CE3, 0, 0, z[0], mk(S_EXECUTE, 0, 0, 1, z[0], 0, 0, 1, 0, 3'b001));
            push(32'hFE208CE3, 0, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        end
        while (sb.size() > 0) begin
            en = sb.pop_front();
            instruction = en.ins; instr_valid = en.iv; dm_ready = en.dr; alu_zero = en.az;
            @(negedge clk);
            checks++;
            if (obs !== en.e) begin errors++; $display("FAIL beq cycle: got %h expected %h", obs, en.e); end
            @(posedge clk); #1;
        end
        checks++;
        if (imm !== 64'hFFFF_FFFF_FFFF_FFF8 || imm32 !== 32'hFFFF_FFF8) begin
            errors++; $display("FAIL beq imm: got %h / %h expected fffffffffffffff8 / fffffff8", imm, imm32);
        end
    endtask

    task automatic test_x0;
        push(32'h00500013, 1, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'h00500013, 0, 0, 0, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'h00500013, 0, 0, 0, mk(S_EXECUTE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'h00500013, 0, 0, 0, mk(S_WRITEBACK, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000));
        push(32'h00500013, 0, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        while (sb.size() > 0) begin
            en = sb.pop_front();
            instruction = en.ins; instr_valid = en.iv; dm_ready = en.dr; alu_zero = en.az;
            @(negedge clk);
            checks++;
            if (obs !== en.e) begin errors++; $display("FAIL addi_x0 cycle: got %h expected %h", obs, en.e); end
            @(posedge clk); #1;
        end
        checks++;
        if (imm !== 64'd5) begin errors++; $display("FAIL addi imm: got %h expected 5", imm); end
    endtask

    task automatic test_sw;
        push(32'hFE20AE23, 1, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'hFE20AE23, 0, 0, 0, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'hFE20AE23, 0, 0, 0, mk(S_EXECUTE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'hFE20AE23, 0, 0, 0, mk(S_MEMORY, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000));
        push(32'hFE20AE23, 0, 1, 0, mk(S_MEMORY, 0, 0, 1, 0, 0, 1, 0, 0, 3'b000));
        push(32'hFE20AE23, 0, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        while (sb.size() > 0) begin
            en = sb.pop_front();
            instruction = en.ins; instr_valid = en.iv; dm_ready = en.dr; alu_zero = en.az;
            @(negedge clk);
            checks++;
            if (obs !== en.e) begin errors++; $display("FAIL sw cycle: got %h expected %h", obs, en.e); end
            @(posedge clk); #1;
        end
        checks++;
        if (imm !== 64'hFFFF_FFFF_FFFF_FFFC || imm32 !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL sw imm: got %h / %h expected fffffffffffffffc / fffffffc", imm, imm32);
        end
    endtask

    task automatic test_sw_reset;
        push(32'h0020A423, 1, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'h0020A423, 0, 0, 0, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'h0020A423, 0, 0, 0, mk(S_EXECUTE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'h0020A423, 0, 0, 0, mk(S_MEMORY, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000));
        while (sb.size() > 0) begin
            en = sb.pop_front();
            instruction = en.ins; instr_valid = en.iv; dm_ready = en.dr; alu_zero = en.az;
            @(negedge clk);
            checks++;
            if (obs !== en.e) begin errors++; $display("FAIL sw_rst cycle: got %h expected %h", obs, en.e); end
            @(posedge clk); #1;
        end
        checks++;
        if (imm !== 64'd8 || imm32 !== 32'd8) begin errors++; $display("FAIL sw imm8: got %h / %h expected 8", imm, imm32); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000) || imm !== 64'd0) begin
            errors++; $display("FAIL sw mid-memory reset: got %h imm=%h expected %h imm=0", obs, imm, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_trap;
        push(32'hFFFFFFFF, 1, 0, 0, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        push(32'hFFFFFFFF, 0, 0, 0, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        for (int k = 0; k < 20; k++) push(32'h002081B3, 1, 1, 1, mk(S_TRAP, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        while (sb.size() > 0) begin
            en = sb.pop_front();
            instruction = en.ins; instr_valid = en.iv; dm_ready = en.dr; alu_zero = en.az;
            @(negedge clk);
            checks++;
            if (obs !== en.e) begin errors++; $display("FAIL trap cycle: got %h expected %h", obs, en.e); end
            @(posedge clk); #1;
        end
        instr_valid = 1'b0; dm_ready = 1'b0; alu_zero = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000) || ill32 !== 1'b0) begin
            errors++; $display("FAIL trap reset: got %h expected %h", obs, mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_add;
        test_back_to_back;
        test_lw;
        test_beq;
        test_x0;
        test_sw;
        test_sw_reset;
        test_trap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
